// File: rtl/accum_seq.sv
// Operand-burst accumulator: clears, sums exactly num_ops operands from a valid/ready
// stream, then holds the sum and a sticky carry flag on a valid/ready result port.
module accum_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4,
  parameter bit SAT   = 1'b0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_ops,
  input  logic             abort,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             overflow,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_ACCUM,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] remaining;
  logic [WIDTH:0]   sum;
  logic             beat;
  logic             last_beat;
  logic             load;

  assign sum       = {1'b0, acc} + {1'b0, in_data};
  assign beat      = (state == S_ACCUM) && in_valid;
  assign last_beat = beat && (remaining == CNT_W'(1));
  assign load      = (state == S_IDLE) && start && !abort && (num_ops != '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    res_valid = 1'b0;
    case (state)
      S_IDLE: begin
        if (load) begin
          state_nxt = S_CLEAR;
        end
      end
      S_CLEAR: begin
        state_nxt = S_ACCUM;
      end
      S_ACCUM: begin
        in_ready = 1'b1;
        if (last_beat) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    // abort wins over every other transition, including res_ready in DONE
    if (abort) begin
      state_nxt = S_IDLE;
    end
  end

  // An operand offered in the abort cycle is still absorbed; only the hand-off is dropped.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc       <= '0;
      overflow  <= 1'b0;
      remaining <= '0;
    end else if (state == S_CLEAR) begin
      acc      <= '0;
      overflow <= 1'b0;
    end else if (beat) begin
      acc       <= (SAT && sum[WIDTH]) ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
      overflow  <= overflow | sum[WIDTH];
      remaining <= remaining - CNT_W'(1);
    end else if (load) begin
      remaining <= num_ops;
    end
  end

  assign res_data = acc;
  assign busy     = (state != S_IDLE);

endmodule

// File: tb/tb_accum_seq.sv
// Directed bench for accum_seq: table of complete operations on wrap and saturate
// instances, plus hand-written gap/stall, ignored-start, abort and reset sequences.
module tb_accum_seq;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       start;
  logic [3:0] num_ops;
  logic       abort;
  logic [7:0] in_data;
  logic       in_valid;
  logic       res_ready;

  logic       in_ready, res_valid, overflow, busy;
  logic [7:0] res_data;
  logic       in_ready_s, res_valid_s, overflow_s, busy_s;
  logic [7:0] res_data_s;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  accum_seq #(.WIDTH(8), .CNT_W(4), .SAT(1'b0)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .num_ops(num_ops), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .res_data(res_data),
    .res_valid(res_valid), .res_ready(res_ready), .overflow(overflow), .busy(busy)
  );

  accum_seq #(.WIDTH(8), .CNT_W(4), .SAT(1'b1)) dut_sat (
    .clock(clock), .reset_n(reset_n), .start(start), .num_ops(num_ops), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_s), .res_data(res_data_s),
    .res_valid(res_valid_s), .res_ready(res_ready), .overflow(overflow_s), .busy(busy_s)
  );

  typedef struct packed {
    logic [3:0]       n;
    logic [14:0][7:0] ops;
    logic [7:0]       exp_wrap;
    logic [7:0]       exp_sat;
    logic             exp_ovf;
  } vec_t;

  vec_t vecs [5];
  vec_t single;

  task automatic check_output(input string name, input logic [15:0] actual,
                              input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // One full operation with in_valid held high, plus an unrequested extra operand in DONE
  task automatic apply_stimulus(input vec_t v, input string tag);
    @(negedge clock);
    start   = 1'b1;
    num_ops = v.n;
    @(negedge clock);
    start = 1'b0;
    check_output({tag, "_clear_in_ready"}, {15'd0, in_ready}, 16'd0);
    check_output({tag, "_clear_busy"}, {15'd0, busy}, 16'd1);
    @(negedge clock);
    for (int i = 0; i < int'(v.n); i++) begin
      check_output({tag, "_beat_in_ready"}, {15'd0, in_ready}, 16'd1);
      in_valid = 1'b1;
      in_data  = v.ops[i];
      @(negedge clock);
    end
    in_data = 8'hFF;
    check_output({tag, "_done_in_ready"}, {15'd0, in_ready}, 16'd0);
    check_output({tag, "_res_valid"}, {15'd0, res_valid}, 16'd1);
    check_output({tag, "_res_data_wrap"}, {8'd0, res_data}, {8'd0, v.exp_wrap});
    check_output({tag, "_overflow_wrap"}, {15'd0, overflow}, {15'd0, v.exp_ovf});
    check_output({tag, "_res_data_sat"}, {8'd0, res_data_s}, {8'd0, v.exp_sat});
    check_output({tag, "_overflow_sat"}, {15'd0, overflow_s}, {15'd0, v.exp_ovf});
    @(negedge clock);
    in_valid = 1'b0;
    check_output({tag, "_res_data_hold"}, {8'd0, res_data}, {8'd0, v.exp_wrap});
    res_ready = 1'b1;
    @(negedge clock);
    res_ready = 1'b0;
    check_output({tag, "_idle_res_valid"}, {15'd0, res_valid}, 16'd0);
    check_output({tag, "_idle_busy"}, {15'd0, busy}, 16'd0);
    check_output({tag, "_idle_res_data"}, {8'd0, res_data}, {8'd0, v.exp_wrap});
  endtask

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    num_ops   = 4'd0;
    abort     = 1'b0;
    in_data   = 8'd0;
    in_valid  = 1'b0;
    res_ready = 1'b0;

    for (int i = 0; i < 5; i++) vecs[i] = '0;
    vecs[0].n = 4'd3;  vecs[0].ops[0] = 8'h10; vecs[0].ops[1] = 8'h20; vecs[0].ops[2] = 8'h30;
    vecs[0].exp_wrap = 8'h60; vecs[0].exp_sat = 8'h60; vecs[0].exp_ovf = 1'b0;
    vecs[1].n = 4'd2;  vecs[1].ops[0] = 8'hF0; vecs[1].ops[1] = 8'h20;
    vecs[1].exp_wrap = 8'h10; vecs[1].exp_sat = 8'hFF; vecs[1].exp_ovf = 1'b1;
    vecs[2].n = 4'd1;  vecs[2].ops[0] = 8'hFF;
    vecs[2].exp_wrap = 8'hFF; vecs[2].exp_sat = 8'hFF; vecs[2].exp_ovf = 1'b0;
    vecs[3].n = 4'd15;
    for (int i = 0; i < 15; i++) vecs[3].ops[i] = 8'h11;
    vecs[3].exp_wrap = 8'hFF; vecs[3].exp_sat = 8'hFF; vecs[3].exp_ovf = 1'b0;
    vecs[4].n = 4'd3;  vecs[4].ops[0] = 8'h80; vecs[4].ops[1] = 8'h80; vecs[4].ops[2] = 8'h01;
    vecs[4].exp_wrap = 8'h01; vecs[4].exp_sat = 8'hFF; vecs[4].exp_ovf = 1'b1;

    repeat (2) @(negedge clock);
    check_output("reset_res_data", {8'd0, res_data}, 16'd0);
    check_output("reset_overflow", {15'd0, overflow}, 16'd0);
    check_output("reset_busy", {15'd0, busy}, 16'd0);
    check_output("reset_in_ready", {15'd0, in_ready}, 16'd0);
    check_output("reset_res_valid", {15'd0, res_valid}, 16'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      apply_stimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // gaps between beats, then a 5-cycle result stall
    $display("[TB] gaps and stall");
    @(negedge clock); start = 1'b1; num_ops = 4'd4;
    @(negedge clock); start = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i + 1);
      @(negedge clock);
      in_valid = 1'b0;
      if (i < 3) begin
        repeat (2) begin
          check_output("gap_in_ready", {15'd0, in_ready}, 16'd1);
          @(negedge clock);
        end
      end
    end
    for (int k = 0; k < 5; k++) begin
      check_output("stall_res_valid", {15'd0, res_valid}, 16'd1);
      check_output("stall_res_data", {8'd0, res_data}, 16'h000A);
      check_output("stall_overflow", {15'd0, overflow}, 16'd0);
      @(negedge clock);
    end
    res_ready = 1'b1;
    @(negedge clock);
    res_ready = 1'b0;
    check_output("stall_release_busy", {15'd0, busy}, 16'd0);
    check_output("stall_release_res_valid", {15'd0, res_valid}, 16'd0);

    // ignored starts
    $display("[TB] ignored starts");
    @(negedge clock); start = 1'b1; num_ops = 4'd0;
    @(negedge clock); start = 1'b0;
    check_output("zero_ops_busy", {15'd0, busy}, 16'd0);
    abort = 1'b1; start = 1'b1; num_ops = 4'd3;
    @(negedge clock); abort = 1'b0; start = 1'b0;
    check_output("abort_over_start_busy", {15'd0, busy}, 16'd0);
    start = 1'b1; num_ops = 4'd2;
    @(negedge clock); start = 1'b0;
    @(negedge clock);
    in_valid = 1'b1; in_data = 8'h05;
    @(negedge clock);
    in_valid = 1'b0; start = 1'b1; num_ops = 4'd9;
    @(negedge clock);
    start = 1'b0;
    check_output("accum_start_in_ready", {15'd0, in_ready}, 16'd1);
    in_valid = 1'b1; in_data = 8'h07;
    @(negedge clock);
    in_valid = 1'b0;
    check_output("accum_start_res_valid", {15'd0, res_valid}, 16'd1);
    check_output("accum_start_res_data", {8'd0, res_data}, 16'h000C);
    start = 1'b1; num_ops = 4'd3; res_ready = 1'b1;
    @(negedge clock);
    start = 1'b0; res_ready = 1'b0;
    check_output("done_start_busy", {15'd0, busy}, 16'd0);
    @(negedge clock);
    check_output("done_start_no_queue", {15'd0, busy}, 16'd0);

    // abort after two of five operands, operand offered in the abort cycle
    $display("[TB] abort");
    start = 1'b1; num_ops = 4'd5;
    @(negedge clock); start = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 8'(i + 1);
      @(negedge clock);
    end
    abort = 1'b1; in_data = 8'h03;
    @(negedge clock);
    abort = 1'b0; in_valid = 1'b0;
    check_output("abort_busy", {15'd0, busy}, 16'd0);
    check_output("abort_in_ready", {15'd0, in_ready}, 16'd0);
    check_output("abort_res_valid", {15'd0, res_valid}, 16'd0);
    repeat (3) begin
      @(negedge clock);
      check_output("abort_no_res_valid", {15'd0, res_valid}, 16'd0);
    end
    single = '0;
    single.n = 4'd1; single.ops[0] = 8'h05;
    single.exp_wrap = 8'h05; single.exp_sat = 8'h05; single.exp_ovf = 1'b0;
    apply_stimulus(single, "after_abort");

    // asynchronous reset in the middle of an accumulation
    $display("[TB] reset mid-operation");
    @(negedge clock); start = 1'b1; num_ops = 4'd3;
    @(negedge clock); start = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 8'hAA;
      @(negedge clock);
    end
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check_output("midreset_res_data", {8'd0, res_data}, 16'd0);
    check_output("midreset_overflow", {15'd0, overflow}, 16'd0);
    check_output("midreset_res_data_sat", {8'd0, res_data_s}, 16'd0);
    check_output("midreset_overflow_sat", {15'd0, overflow_s}, 16'd0);
    check_output("midreset_busy", {15'd0, busy}, 16'd0);
    check_output("midreset_in_ready", {15'd0, in_ready}, 16'd0);
    check_output("midreset_res_valid", {15'd0, res_valid}, 16'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check_output("post_reset_busy", {15'd0, busy}, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
